// File: rtl/sram_axi_slave_if.sv
// ---------------------------------------------------------------------------
// sram_axi_slave_if
// AXI4 bus bundle between an interconnect master port and the SRAM slave.
//
// Signal groups:
//   AW : AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID / AWREADY
//   W  : WDATA, WSTRB, WLAST, WVALID / WREADY
//   B  : BID, BRESP, BVALID / BREADY
//   AR : ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID / ARREADY
//   R  : RID, RDATA, RRESP, RLAST, RVALID / RREADY
//
// Modports:
//   master : drives requests, write data and response ready
//   slave  : drives address/data ready, responses and read data
// WSTRB is active-low: a 0 bit means that byte is written.
// ---------------------------------------------------------------------------
interface sram_axi_slave_if #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);

   logic [ID_W-1:0]   AWID;
   logic [ADDR_W-1:0] AWADDR;
   logic [LEN_W-1:0]  AWLEN;
   logic [2:0]        AWSIZE;
   logic [1:0]        AWBURST;
   logic              AWVALID;
   logic              AWREADY;

   logic [DATA_W-1:0] WDATA;
   logic [3:0]        WSTRB;
   logic              WLAST;
   logic              WVALID;
   logic              WREADY;

   logic [ID_W-1:0]   BID;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;

   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [LEN_W-1:0]  ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;

   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

endinterface

// File: rtl/sram_axi_slave.sv
// ---------------------------------------------------------------------------
// sram_axi_slave
// AXI4 slave that terminates one interconnect master port and drives a
// single-port synchronous SRAM macro (2^SRAM_AW words of DATA_W bits).
// Single beats and INCR bursts are turned into SRAM chip-enable, byte
// write-enable and address cycles. Bursts wrap modulo the SRAM size.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : AXI4 slave modport (AW/W/B/AR/R channels)
//   CEB  : SRAM chip enable, active-low
//   WEB  : SRAM byte write enable, active-low
//   A    : SRAM word address
//   DI   : SRAM write data
//   DO   : SRAM read data, valid the cycle after a read enable
// ---------------------------------------------------------------------------
module sram_axi_slave #(
   parameter int ID_W    = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 4,
   parameter int SRAM_AW = 14
) (
   input  logic                clk,
   input  logic                rst,
   sram_axi_slave_if.slave     bus,
   output logic                CEB,
   output logic [3:0]          WEB,
   output logic [SRAM_AW-1:0]  A,
   output logic [DATA_W-1:0]   DI,
   input  logic [DATA_W-1:0]   DO
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RDATA,
      S_WDATA,
      S_WRESP
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [SRAM_AW-1:0] addr_q;
   logic [SRAM_AW-1:0] addr_d;
   logic [LEN_W-1:0]   beat_q;
   logic [LEN_W-1:0]   beat_d;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   len_d;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    id_d;
   logic               last_beat;

   // Burst type, size, write length and the address bits outside the
   // SRAM window carry no information for a fixed 32-bit INCR-only slave.
   logic unused_bits;
   assign unused_bits = ^{bus.AWLEN, bus.AWSIZE, bus.AWBURST,
                          bus.ARSIZE, bus.ARBURST,
                          bus.AWADDR[ADDR_W-1:SRAM_AW+2], bus.AWADDR[1:0],
                          bus.ARADDR[ADDR_W-1:SRAM_AW+2], bus.ARADDR[1:0]};

   assign last_beat = (beat_q == len_q);

   // State and transaction context registers. The word address register
   // also supplies A while idle, so A keeps its last value between
   // transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         addr_q <= '0;
         beat_q <= '0;
         len_q  <= '0;
         id_q   <= '0;
      end else begin
         state  <= state_next;
         addr_q <= addr_d;
         beat_q <= beat_d;
         len_q  <= len_d;
         id_q   <= id_d;
      end
   end

   // Next state, context updates and every bus/SRAM output. All outputs
   // are forced to their quiet values while rst is high, so the macro
   // sees no access even in the cycle a mid-burst reset is applied.
   // In a read burst A runs one beat ahead on a non-last R handshake:
   // the SRAM needs the next address a cycle early so DO carries the
   // next word exactly when the following beat is presented.
   always_comb begin
      state_next  = state;
      addr_d      = addr_q;
      beat_d      = beat_q;
      len_d       = len_q;
      id_d        = id_q;
      CEB         = 1'b1;
      WEB         = 4'hF;
      A           = addr_q;
      DI          = '0;
      bus.AWREADY = 1'b0;
      bus.WREADY  = 1'b0;
      bus.BID     = '0;
      bus.BRESP   = 2'b00;
      bus.BVALID  = 1'b0;
      bus.ARREADY = 1'b0;
      bus.RID     = '0;
      bus.RDATA   = '0;
      bus.RRESP   = 2'b00;
      bus.RLAST   = 1'b0;
      bus.RVALID  = 1'b0;

      if (rst) begin
         A = '0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.ARREADY = 1'b1;
               bus.AWREADY = ~bus.ARVALID;
               if (bus.ARVALID) begin
                  CEB        = 1'b0;
                  A          = bus.ARADDR[SRAM_AW+1:2];
                  addr_d     = bus.ARADDR[SRAM_AW+1:2];
                  beat_d     = '0;
                  len_d      = bus.ARLEN;
                  id_d       = bus.ARID;
                  state_next = S_RDATA;
               end else if (bus.AWVALID) begin
                  addr_d     = bus.AWADDR[SRAM_AW+1:2];
                  id_d       = bus.AWID;
                  state_next = S_WDATA;
               end
            end

            S_RDATA: begin
               bus.RVALID = 1'b1;
               bus.RDATA  = DO;
               bus.RID    = id_q;
               bus.RLAST  = last_beat;
               CEB        = 1'b0;
               if (bus.RREADY) begin
                  if (last_beat) begin
                     state_next = S_IDLE;
                  end else begin
                     A      = addr_q + SRAM_AW'(1);
                     addr_d = addr_q + SRAM_AW'(1);
                     beat_d = beat_q + LEN_W'(1);
                  end
               end
            end

            S_WDATA: begin
               bus.WREADY = 1'b1;
               DI         = bus.WDATA;
               if (bus.WVALID) begin
                  CEB    = 1'b0;
                  WEB    = bus.WSTRB;
                  addr_d = addr_q + SRAM_AW'(1);
                  if (bus.WLAST) begin
                     state_next = S_WRESP;
                  end
               end
            end

            S_WRESP: begin
               bus.BVALID = 1'b1;
               bus.BID    = id_q;
               if (bus.BREADY) begin
                  state_next = S_IDLE;
               end
            end

            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_slave
// Directed bench for sram_axi_slave: a behavioural 16K x 32 SRAM answers
// the macro pins, and each scenario drives the AXI channels cycle by cycle
// and compares outputs against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_axi_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        CEB;
   logic [3:0]  WEB;
   logic [13:0] A;
   logic [31:0] DI;
   logic [31:0] DO;

   logic [31:0] mem [0:16383];
   logic [31:0] expData [0:15];

   int checks = 0;
   int errors = 0;

   sram_axi_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

   sram_axi_slave #(
      .ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .SRAM_AW(14)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .CEB (CEB),
      .WEB (WEB),
      .A   (A),
      .DI  (DI),
      .DO  (DO)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Behavioural SRAM: a read registers DO, a write updates the bytes
   // whose active-low enable is 0.
   always @(posedge clk) begin
      if (!CEB) begin
         if (WEB == 4'hF) begin
            DO <= mem[A];
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (!WEB[k]) begin
                  mem[A][8*k +: 8] <= DI[8*k +: 8];
               end
            end
         end
      end
   end

   // Count a comparison and report it when the values differ.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Return all master-driven signals to an idle bus.
   task automatic applyStimulus();
      bus.AWID    = '0;
      bus.AWADDR  = '0;
      bus.AWLEN   = '0;
      bus.AWSIZE  = 3'd2;
      bus.AWBURST = 2'b01;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WSTRB   = 4'hF;
      bus.WLAST   = 1'b0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;
      bus.ARID    = '0;
      bus.ARADDR  = '0;
      bus.ARLEN   = '0;
      bus.ARSIZE  = 3'd2;
      bus.ARBURST = 2'b01;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one read burst and check every beat against expData. The beat
   // numbered stallBeat is held with RREADY low for stallCycles cycles.
   task automatic readBurst(input string tag, input logic [31:0] addr,
                            input logic [3:0] len, input logic [7:0] id,
                            input int stallBeat, input int stallCycles);
      logic [13:0] wordA;
      wordA       = addr[15:2];
      bus.ARVALID = 1'b1;
      bus.ARADDR  = addr;
      bus.ARLEN   = len;
      bus.ARID    = id;
      bus.RREADY  = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".arready"}, 64'(bus.ARREADY), 64'd1);
      checkOutput({tag, ".ceb_ar"}, 64'(CEB), 64'd0);
      checkOutput({tag, ".a_ar"}, 64'(A), 64'(wordA));
      step();
      bus.ARVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (b == stallBeat) begin
            bus.RREADY = 1'b0;
            for (int s = 0; s < stallCycles; s++) begin
               @(negedge clk);
               checkOutput({tag, ".stall_rvalid"}, 64'(bus.RVALID), 64'd1);
               checkOutput({tag, ".stall_rdata"}, 64'(bus.RDATA), 64'(expData[b]));
               checkOutput({tag, ".stall_a"}, 64'(A), 64'(wordA + 14'(b)));
               step();
            end
            bus.RREADY = 1'b1;
         end
         @(negedge clk);
         checkOutput({tag, ".rvalid"}, 64'(bus.RVALID), 64'd1);
         checkOutput({tag, ".rdata"}, 64'(bus.RDATA), 64'(expData[b]));
         checkOutput({tag, ".rlast"}, 64'(bus.RLAST), 64'(b == int'(len)));
         checkOutput({tag, ".rid"}, 64'(bus.RID), 64'(id));
         checkOutput({tag, ".rresp"}, 64'(bus.RRESP), 64'd0);
         step();
      end
      bus.RREADY = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".rvalid_done"}, 64'(bus.RVALID), 64'd0);
      checkOutput({tag, ".ceb_done"}, 64'(CEB), 64'd1);
      step();
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[14'h0010] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem[14'h0040 + i] = 32'hC0DE_0040 + i;
      mem[14'h0081] = 32'h11223344;
      mem[14'h3FFF] = 32'hFFFF0001;
      mem[14'h0000] = 32'h00000F00;

      // Reset, with a read request pending that must be ignored.
      applyStimulus();
      rst = 1'b1;
      bus.ARVALID = 1'b1;
      bus.ARADDR  = 32'h0000_0040;
      step();
      @(negedge clk);
      checkOutput("rst.arready", 64'(bus.ARREADY), 64'd0);
      checkOutput("rst.awready", 64'(bus.AWREADY), 64'd0);
      checkOutput("rst.ceb", 64'(CEB), 64'd1);
      checkOutput("rst.web", 64'(WEB), 64'hF);
      checkOutput("rst.a", 64'(A), 64'd0);
      checkOutput("rst.rvalid", 64'(bus.RVALID), 64'd0);
      checkOutput("rst.bvalid", 64'(bus.BVALID), 64'd0);
      step();
      bus.ARVALID = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle.arready", 64'(bus.ARREADY), 64'd1);
      checkOutput("idle.awready", 64'(bus.AWREADY), 64'd1);
      checkOutput("idle.ceb", 64'(CEB), 64'd1);
      step();

      // Single-beat read.
      expData[0] = 32'hDEADBEEF;
      readBurst("single", 32'h0000_0040, 4'd0, 8'h12, -1, 0);

      // Four-beat read, second beat stalled for three cycles.
      for (int i = 0; i < 4; i++) expData[i] = 32'hC0DE_0040 + i;
      readBurst("burst", 32'h0000_0100, 4'd3, 8'h21, 1, 3);

      // Byte write: only byte 0 enabled (active-low strobe).
      bus.AWVALID = 1'b1;
      bus.AWADDR  = 32'h0000_0204;
      bus.AWID    = 8'h5A;
      @(negedge clk);
      checkOutput("bw.awready", 64'(bus.AWREADY), 64'd1);
      step();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b1;
      bus.WDATA   = 32'hAABBCCDD;
      bus.WSTRB   = 4'b1110;
      bus.WLAST   = 1'b1;
      @(negedge clk);
      checkOutput("bw.wready", 64'(bus.WREADY), 64'd1);
      checkOutput("bw.ceb", 64'(CEB), 64'd0);
      checkOutput("bw.web", 64'(WEB), 64'b1110);
      checkOutput("bw.a", 64'(A), 64'h81);
      checkOutput("bw.di", 64'(DI), 64'hAABBCCDD);
      step();
      bus.WVALID = 1'b0;
      bus.WLAST  = 1'b0;
      @(negedge clk);
      checkOutput("bw.bvalid", 64'(bus.BVALID), 64'd1);
      checkOutput("bw.bid", 64'(bus.BID), 64'h5A);
      checkOutput("bw.bresp", 64'(bus.BRESP), 64'd0);
      checkOutput("bw.ceb_resp", 64'(CEB), 64'd1);
      step();
      @(negedge clk);
      checkOutput("bw.bvalid_hold", 64'(bus.BVALID), 64'd1);
      step();
      bus.BREADY = 1'b1;
      step();
      bus.BREADY = 1'b0;
      @(negedge clk);
      checkOutput("bw.bvalid_done", 64'(bus.BVALID), 64'd0);
      checkOutput("bw.mem", 64'(mem[14'h0081]), 64'h112233DD);
      step();

      // Simultaneous AR and AW: the read goes first.
      bus.ARVALID = 1'b1;
      bus.ARADDR  = 32'h0000_0040;
      bus.ARLEN   = 4'd0;
      bus.ARID    = 8'h33;
      bus.AWVALID = 1'b1;
      bus.AWADDR  = 32'h0000_0208;
      bus.AWID    = 8'h44;
      bus.RREADY  = 1'b1;
      @(negedge clk);
      checkOutput("both.arready", 64'(bus.ARREADY), 64'd1);
      checkOutput("both.awready", 64'(bus.AWREADY), 64'd0);
      step();
      bus.ARVALID = 1'b0;
      @(negedge clk);
      checkOutput("both.rvalid", 64'(bus.RVALID), 64'd1);
      checkOutput("both.rdata", 64'(bus.RDATA), 64'hDEADBEEF);
      checkOutput("both.rid", 64'(bus.RID), 64'h33);
      checkOutput("both.awready_busy", 64'(bus.AWREADY), 64'd0);
      step();
      bus.RREADY = 1'b0;
      @(negedge clk);
      checkOutput("both.awready_after", 64'(bus.AWREADY), 64'd1);
      step();
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b1;
      bus.WDATA   = 32'h12345678;
      bus.WSTRB   = 4'b0000;
      bus.WLAST   = 1'b1;
      @(negedge clk);
      checkOutput("both.wready", 64'(bus.WREADY), 64'd1);
      checkOutput("both.a", 64'(A), 64'h82);
      step();
      bus.WVALID = 1'b0;
      bus.WLAST  = 1'b0;
      bus.BREADY = 1'b1;
      @(negedge clk);
      checkOutput("both.bvalid", 64'(bus.BVALID), 64'd1);
      checkOutput("both.bid", 64'(bus.BID), 64'h44);
      step();
      bus.BREADY = 1'b0;
      @(negedge clk);
      checkOutput("both.mem", 64'(mem[14'h0082]), 64'h12345678);
      step();

      // Burst crossing the top of the SRAM wraps to word 0.
      expData[0] = 32'hFFFF0001;
      expData[1] = 32'h00000F00;
      readBurst("wrap", 32'h0000_FFFC, 4'd1, 8'h07, -1, 0);

      // Reset during the third beat of a four-beat read.
      bus.ARVALID = 1'b1;
      bus.ARADDR  = 32'h0000_0100;
      bus.ARLEN   = 4'd3;
      bus.ARID    = 8'h66;
      bus.RREADY  = 1'b1;
      step();
      bus.ARVALID = 1'b0;
      @(negedge clk);
      checkOutput("rstmid.beat0", 64'(bus.RDATA), 64'hC0DE0040);
      step();
      @(negedge clk);
      checkOutput("rstmid.beat1", 64'(bus.RDATA), 64'hC0DE0041);
      step();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstmid.rvalid_rst", 64'(bus.RVALID), 64'd0);
      checkOutput("rstmid.ceb_rst", 64'(CEB), 64'd1);
      step();
      rst = 1'b0;
      bus.RREADY = 1'b0;
      @(negedge clk);
      checkOutput("rstmid.rvalid", 64'(bus.RVALID), 64'd0);
      checkOutput("rstmid.ceb", 64'(CEB), 64'd1);
      checkOutput("rstmid.arready", 64'(bus.ARREADY), 64'd1);
      step();
      expData[0] = 32'hDEADBEEF;
      readBurst("rstmid.reread", 32'h0000_0040, 4'd0, 8'h77, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
